// File: rtl/load_align_unit_if.sv
// Load request / data memory / response bundle for load_align_unit.
interface load_align_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_misaligned;

  // Requester / memory side.
  modport master (
    output req_valid, req_addr, req_size, req_signed, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_misaligned
  );

  // Load unit side.
  modport slave (
    input  req_valid, req_addr, req_size, req_signed, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_misaligned
  );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load aligner: word-aligned memory reads, big-endian byte extraction,
// sign/zero extension, optional two-read handling of boundary-crossing accesses.
module load_align_unit #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          ALLOW_UNALIGNED = 1'b1
) (
  input  logic           Clk,
  input  logic           Reset,
  load_align_unit_if.slave bus
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFS_W = $clog2(BYTES);
  localparam int unsigned NB_W  = OFS_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t state, state_next;

  // Latched request context.
  logic [ADDR_W-1:0] addr_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [NB_W-1:0]   nbytes_q;
  logic              signed_q;
  logic              cross_q;
  logic [XLEN-1:0]   lo_q;

  // Registered outputs and their next values.
  logic              req_ready_q, req_ready_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              misal_q, misal_d;

  // Request decode.
  logic [OFS_W-1:0]  req_ofs;
  logic [NB_W-1:0]   req_nbytes;
  logic              req_legal;
  logic              req_reject;
  logic              req_cross;
  logic              accept;
  logic [ADDR_W-1:0] req_base;

  // Decode size, legality, alignment and word-crossing of the incoming request.
  always_comb begin
    req_ofs   = bus.req_addr[OFS_W-1:0];
    req_base  = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    req_legal = 1'b1;
    case (bus.req_size)
      2'd0:    req_nbytes = NB_W'(BYTES);
      2'd1:    req_nbytes = NB_W'(1);
      2'd2:    req_nbytes = NB_W'(2);
      default: begin
        req_nbytes = NB_W'(4);
        req_legal  = (XLEN == 64);
      end
    endcase
    req_reject = !req_legal ||
                 (!ALLOW_UNALIGNED && ((req_ofs & OFS_W'(req_nbytes - NB_W'(1))) != '0));
    req_cross  = (NB_W'(req_ofs) + req_nbytes) > NB_W'(BYTES);
    accept     = bus.req_valid && req_ready_q;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_reject ? ERR : RD0;
      RD0:     state_next = cross_q ? RD1 : CAP;
      RD1:     state_next = CAP;
      CAP:     state_next = RSP;
      ERR:     state_next = RSP;
      RSP:     if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte extraction: byte 0 sits in the MSBs, so shift the selected bytes to the top,
  // then right-shift (logical or arithmetic) to land them in the LSBs extended.
  logic [2*XLEN-1:0] window;
  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   top;
  logic [NB_W-1:0]   pad;
  logic [XLEN-1:0]   extracted;

  always_comb begin
    window  = cross_q ? {lo_q, bus.mem_rdata} : {bus.mem_rdata, {XLEN{1'b0}}};
    shifted = window << {ofs_q, 3'b000};
    top     = shifted[2*XLEN-1 -: XLEN];
    pad     = NB_W'(BYTES) - nbytes_q;
    if (signed_q) extracted = $signed(top) >>> {pad, 3'b000};
    else          extracted = top >> {pad, 3'b000};
  end

  // Output next values, computed from the state being entered / the state being left.
  always_comb begin
    req_ready_d = (state_next == IDLE);
    rd_en_d     = 1'b0;
    mem_addr_d  = '0;
    rsp_valid_d = (state_next == RSP);
    rsp_data_d  = rsp_data_q;
    misal_d     = misal_q;
    case (state_next)
      RD0: begin
        rd_en_d    = 1'b1;
        mem_addr_d = req_base;
      end
      RD1: begin
        rd_en_d    = 1'b1;
        mem_addr_d = addr_q + ADDR_W'(BYTES);
      end
      default: ;
    endcase
    case (state)
      CAP: begin
        rsp_data_d = extracted;
        misal_d    = 1'b0;
      end
      ERR: begin
        rsp_data_d = '0;
        misal_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Request context capture and low-word latch for crossing accesses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q   <= '0;
      ofs_q    <= '0;
      nbytes_q <= '0;
      signed_q <= 1'b0;
      cross_q  <= 1'b0;
      lo_q     <= '0;
    end else begin
      if (state == IDLE && accept) begin
        addr_q   <= req_base;
        ofs_q    <= req_ofs;
        nbytes_q <= req_nbytes;
        signed_q <= bus.req_signed;
        cross_q  <= req_cross && !req_reject;
      end
      if (state == RD1) lo_q <= bus.mem_rdata;
    end
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      misal_q     <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rd_en_q     <= rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      misal_q     <= misal_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.mem_rd_en      = rd_en_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_misaligned = misal_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: one unaligned-capable and one strict instance share stimulus.
module tb_load_align_unit;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_u ();
  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_a ();

  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b1)) dut_u (
    .Clk(Clk), .Reset(Reset), .bus(bus_u));
  load_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem [16];

  // Word memory with one-cycle read latency; junk on the bus when not reading.
  always @(posedge Clk) begin
    bus_u.mem_rdata <= bus_u.mem_rd_en ? mem[bus_u.mem_addr[5:2]] : $urandom();
    bus_a.mem_rdata <= bus_a.mem_rd_en ? mem[bus_a.mem_addr[5:2]] : $urandom();
  end

  // Index 0 = unaligned-capable unit, 1 = strict unit.
  logic [1:0]  m_rd_en, m_rsp_valid, m_req_ready, m_mis, m_req_valid, m_rsp_ready;
  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  assign m_rd_en     = {bus_a.mem_rd_en, bus_u.mem_rd_en};
  assign m_rsp_valid = {bus_a.rsp_valid, bus_u.rsp_valid};
  assign m_req_ready = {bus_a.req_ready, bus_u.req_ready};
  assign m_mis       = {bus_a.rsp_misaligned, bus_u.rsp_misaligned};
  assign m_req_valid = {bus_a.req_valid, bus_u.req_valid};
  assign m_rsp_ready = {bus_a.rsp_ready, bus_u.rsp_ready};
  assign m_addr[0]   = bus_u.mem_addr;
  assign m_addr[1]   = bus_a.mem_addr;
  assign m_data[0]   = bus_u.rsp_data;
  assign m_data[1]   = bus_a.rsp_data;

  int          cyc = 0;
  int          acc_cyc [2], rsp_cyc [2], hs_cyc [2], nrd [2], cnt_acc [2], cnt_hs [2];
  logic [31:0] rd_addr [2][4];
  logic [31:0] hs_data [2];
  logic        hs_mis [2];
  bit          seen [2];

  // Bus monitor: accepts, reads issued, first response cycle, handshakes.
  always @(posedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!Reset) begin
        if (m_req_valid[d] && m_req_ready[d]) begin
          acc_cyc[d] <= cyc;
          cnt_acc[d] <= cnt_acc[d] + 1;
          nrd[d]     <= 0;
          seen[d]    <= 1'b0;
        end else begin
          if (m_rd_en[d]) begin
            if (nrd[d] < 4) rd_addr[d][nrd[d]] <= m_addr[d];
            nrd[d] <= nrd[d] + 1;
          end
          if (m_rsp_valid[d] && !seen[d]) begin
            seen[d]    <= 1'b1;
            rsp_cyc[d] <= cyc;
          end
        end
        if (m_rsp_valid[d] && m_rsp_ready[d]) begin
          hs_cyc[d]  <= cyc;
          cnt_hs[d]  <= cnt_hs[d] + 1;
          hs_data[d] <= m_data[d];
          hs_mis[d]  <= m_mis[d];
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Reference model: assemble the load byte by byte from big-endian memory.
  function automatic void model(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                                input bit allow, output logic [31:0] data, output logic mis,
                                output int lat, output int nr, output logic [31:0] r0,
                                output logic [31:0] r1);
    int n;
    logic [31:0] a, w, val, first, last;
    n = (size == 2'd0) ? 4 : (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 0;
    data = 32'h0; mis = 1'b1; lat = 2; nr = 0; r0 = 32'h0; r1 = 32'h0;
    if (n == 0) return;
    if (!allow && (addr % 32'(n)) != 32'h0) return;
    val = 32'h0;
    for (int i = 0; i < n; i++) begin
      a   = addr + 32'(i);
      w   = mem[a[5:2]];
      val = (val << 8) | ((w >> (8 * (3 - int'(a[1:0])))) & 32'hFF);
    end
    if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'h1 << (8 * n)) - 32'h1);
    mis   = 1'b0;
    data  = val;
    first = addr & ~32'h3;
    last  = (addr + 32'(n) - 32'h1) & ~32'h3;
    r0    = first;
    r1    = first + 32'h4;
    if (first != last) begin nr = 2; lat = 4; end
    else               begin nr = 1; lat = 3; end
  endfunction

  task automatic drive_req(input logic v, input logic [31:0] a, input logic [1:0] s, input logic sg);
    bus_u.req_valid = v; bus_u.req_addr = a; bus_u.req_size = s; bus_u.req_signed = sg;
    bus_a.req_valid = v; bus_a.req_addr = a; bus_a.req_size = s; bus_a.req_signed = sg;
  endtask

  task automatic set_rsp_ready(input logic r);
    bus_u.rsp_ready = r;
    bus_a.rsp_ready = r;
  endtask

  task automatic idle_req();
    drive_req(1'b0, $urandom(), 2'($urandom()), 1'($urandom()));
  endtask

  task automatic wait_ready(output bit to);
    int k = 0;
    to = 1'b0;
    while (m_req_ready != 2'b11 && k < 20) begin @(negedge Clk); k++; end
    if (k >= 20) to = 1'b1;
  endtask

  logic [31:0] r_data [2];
  logic        r_mis [2];
  int          r_lat [2], r_nrd [2];
  logic [31:0] r_rd0 [2], r_rd1 [2];
  bit          r_timeout;

  // One full transaction on both units; results collected, checks left to the caller.
  task automatic run_txn(input logic [31:0] addr, input logic [1:0] size, input logic sg);
    int k;
    bit to;
    @(negedge Clk);
    wait_ready(to);
    r_timeout = to;
    set_rsp_ready(1'b0);
    drive_req(1'b1, addr, size, sg);
    @(negedge Clk);
    idle_req();
    k = 0;
    while (!(seen[0] && seen[1]) && k < 20) begin @(negedge Clk); k++; end
    if (k >= 20) r_timeout = 1'b1;
    for (int d = 0; d < 2; d++) begin
      r_data[d] = m_data[d];
      r_mis[d]  = m_mis[d];
      r_lat[d]  = rsp_cyc[d] - acc_cyc[d];
      r_nrd[d]  = nrd[d];
      r_rd0[d]  = rd_addr[d][0];
      r_rd1[d]  = rd_addr[d][1];
    end
    set_rsp_ready(1'b1);
    @(negedge Clk);
    set_rsp_ready(1'b0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_req();
    set_rsp_ready(1'b0);
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    mem[0]  = 32'h0ACFFB19;
    mem[1]  = 32'h11223344;
    mem[15] = 32'hDEADBEEF;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({m_rsp_valid[d], m_mis[d], m_rd_en[d], m_req_ready[d]} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_ctrl dut%0d: got valid/mis/rd_en/ready=%b required 0000", d,
                 {m_rsp_valid[d], m_mis[d], m_rd_en[d], m_req_ready[d]});
      end
      n_cmp++;
      if (m_data[d] !== 32'h0 || m_addr[d] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_data dut%0d: got data=%h addr=%h required 0/0", d, m_data[d], m_addr[d]);
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (m_req_ready !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_ready: got %b required 11", m_req_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] t_addr [13] = '{32'h0, 32'h1, 32'h1, 32'h3, 32'h2, 32'h0, 32'h0, 32'h2,
                                 32'h3, 32'h1, 32'hFFFFFFFE, 32'h4, 32'h7};
    logic [1:0]  t_size [13] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0,
                                 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};
    logic        t_sgn  [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_exp  [13] = '{32'h0ACFFB19, 32'hFFFFFFCF, 32'h000000CF, 32'h00000019,
                                 32'hFFFFFB19, 32'h00000ACF, 32'h00000000, 32'hFB191122,
                                 32'h00001911, 32'h0000CFFB, 32'hBEEF0ACF, 32'h11223344,
                                 32'h00000044};
    logic        t_misa [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ed, e0, e1;
    logic        em;
    int          el, en;
    for (int i = 0; i < 13; i++) begin
      run_txn(t_addr[i], t_size[i], t_sgn[i]);
      n_cmp++;
      if (r_data[0] !== t_exp[i]) begin
        n_bad++;
        $display("FAIL dir_value #%0d: got %h required %h", i, r_data[0], t_exp[i]);
      end
      n_cmp++;
      if (r_mis[1] !== t_misa[i]) begin
        n_bad++;
        $display("FAIL dir_strict_flag #%0d: got %b required %b", i, r_mis[1], t_misa[i]);
      end
      for (int d = 0; d < 2; d++) begin
        model(t_addr[i], t_size[i], t_sgn[i], d == 0, ed, em, el, en, e0, e1);
        n_cmp++;
        if (r_timeout) begin n_bad++; $display("FAIL dir_timeout #%0d dut%0d: no response", i, d); end
        n_cmp++;
        if (r_data[d] !== ed || r_mis[d] !== em) begin
          n_bad++;
          $display("FAIL dir_rsp #%0d dut%0d: got %h/%b required %h/%b", i, d, r_data[d], r_mis[d], ed, em);
        end
        n_cmp++;
        if (r_lat[d] !== el) begin
          n_bad++;
          $display("FAIL dir_latency #%0d dut%0d: got %0d required %0d", i, d, r_lat[d], el);
        end
        n_cmp++;
        if (r_nrd[d] !== en || (en > 0 && r_rd0[d] !== e0) || (en > 1 && r_rd1[d] !== e1)) begin
          n_bad++;
          $display("FAIL dir_reads #%0d dut%0d: got n=%0d %h %h required n=%0d %h %h",
                   i, d, r_nrd[d], r_rd0[d], r_rd1[d], en, e0, e1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, ed, e0, e1;
    logic [1:0]  s;
    logic        sg, em;
    int          el, en;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom();
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      s  = 2'($urandom_range(0, 3));
      sg = 1'($urandom());
      run_txn(a, s, sg);
      for (int d = 0; d < 2; d++) begin
        model(a, s, sg, d == 0, ed, em, el, en, e0, e1);
        n_cmp++;
        if (r_timeout || r_data[d] !== ed || r_mis[d] !== em) begin
          n_bad++;
          $display("FAIL rnd_rsp a=%h s=%0d sg=%b dut%0d: got %h/%b to=%b required %h/%b",
                   a, s, sg, d, r_data[d], r_mis[d], r_timeout, ed, em);
        end
        n_cmp++;
        if (r_lat[d] !== el) begin
          n_bad++;
          $display("FAIL rnd_latency a=%h dut%0d: got %0d required %0d", a, d, r_lat[d], el);
        end
        n_cmp++;
        if (r_nrd[d] !== en || (en > 0 && r_rd0[d] !== e0) || (en > 1 && r_rd1[d] !== e1)) begin
          n_bad++;
          $display("FAIL rnd_reads a=%h dut%0d: got n=%0d %h %h required n=%0d %h %h",
                   a, d, r_nrd[d], r_rd0[d], r_rd1[d], en, e0, e1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_d [2];
    logic        snap_m [2];
    int          k;
    bit          to;
    @(negedge Clk);
    wait_ready(to);
    set_rsp_ready(1'b0);
    drive_req(1'b1, 32'h2, 2'd0, 1'b0);
    @(negedge Clk);
    idle_req();
    k = 0;
    while (!(seen[0] && seen[1]) && k < 20) begin @(negedge Clk); k++; end
    n_cmp++;
    if (to || k >= 20) begin n_bad++; $display("FAIL bp_timeout: no response"); end
    for (int d = 0; d < 2; d++) begin snap_d[d] = m_data[d]; snap_m[d] = m_mis[d]; end
    n_cmp++;
    if (snap_d[0] !== 32'hFB191122 || snap_m[0] !== 1'b0 || snap_d[1] !== 32'h0 || snap_m[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_value: got %h/%b %h/%b required fb191122/0 00000000/1",
               snap_d[0], snap_m[0], snap_d[1], snap_m[1]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (m_rsp_valid[d] !== 1'b1 || m_req_ready[d] !== 1'b0 ||
            m_data[d] !== snap_d[d] || m_mis[d] !== snap_m[d]) begin
          n_bad++;
          $display("FAIL bp_hold c%0d dut%0d: got v=%b rdy=%b %h/%b required v=1 rdy=0 %h/%b",
                   c, d, m_rsp_valid[d], m_req_ready[d], m_data[d], m_mis[d], snap_d[d], snap_m[d]);
        end
      end
    end
    set_rsp_ready(1'b1);
    @(negedge Clk);
    set_rsp_ready(1'b0);
    n_cmp++;
    if (m_rsp_valid !== 2'b00 || m_req_ready !== 2'b11) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b ready=%b required 00/11", m_rsp_valid, m_req_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    @(negedge Clk);
    wait_ready(to);
    set_rsp_ready(1'b0);
    drive_req(1'b1, 32'h2, 2'd0, 1'b0);
    @(negedge Clk);
    idle_req();
    @(negedge Clk);
    n_cmp++;
    if (to || m_rd_en[0] !== 1'b1 || m_addr[0] !== 32'h4) begin
      n_bad++;
      $display("FAIL rst_mid_rd1: got rd_en=%b addr=%h required 1/00000004", m_rd_en[0], m_addr[0]);
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (m_rsp_valid !== 2'b00 || m_rd_en !== 2'b00 || m_req_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got valid=%b rd_en=%b ready=%b required 00/00/00",
               m_rsp_valid, m_rd_en, m_req_ready);
    end
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (m_rsp_valid !== 2'b00) begin
        n_bad++;
        $display("FAIL rst_mid_no_rsp c%0d: got valid=%b required 00", c, m_rsp_valid);
      end
    end
    n_cmp++;
    if (m_req_ready !== 2'b11) begin
      n_bad++;
      $display("FAIL rst_mid_ready: got %b required 11", m_req_ready);
    end
    run_txn(32'h1, 2'd1, 1'b1);
    n_cmp++;
    if (r_timeout || r_data[0] !== 32'hFFFFFFCF || r_data[1] !== 32'hFFFFFFCF || r_mis[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_after: got %h %h mis=%b required ffffffcf ffffffcf 0",
               r_data[0], r_data[1], r_mis[0]);
    end
  endtask

  task automatic test_back_to_back();
    int s_acc [2], s_hs [2];
    int k;
    bit to;
    @(negedge Clk);
    wait_ready(to);
    for (int d = 0; d < 2; d++) begin s_acc[d] = cnt_acc[d]; s_hs[d] = cnt_hs[d]; end
    set_rsp_ready(1'b1);
    drive_req(1'b1, 32'h1, 2'd1, 1'b1);
    k = 0;
    while (!(cnt_acc[0] >= s_acc[0] + 2 && cnt_acc[1] >= s_acc[1] + 2) && k < 30) begin
      @(negedge Clk);
      k++;
    end
    idle_req();
    n_cmp++;
    if (to || k >= 30) begin n_bad++; $display("FAIL b2b_timeout: second accept missing"); end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (acc_cyc[d] !== hs_cyc[d] + 1 || cnt_hs[d] !== s_hs[d] + 1) begin
        n_bad++;
        $display("FAIL b2b_gap dut%0d: got accept=%0d handshake=%0d hs_count=%0d required accept=handshake+1 count=%0d",
                 d, acc_cyc[d], hs_cyc[d], cnt_hs[d] - s_hs[d], 1);
      end
    end
    k = 0;
    while (!(cnt_hs[0] >= s_hs[0] + 2 && cnt_hs[1] >= s_hs[1] + 2) && k < 30) begin
      @(negedge Clk);
      k++;
    end
    set_rsp_ready(1'b0);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (k >= 30 || hs_data[d] !== 32'hFFFFFFCF || hs_mis[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_second dut%0d: got %h/%b required ffffffcf/0", d, hs_data[d], hs_mis[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
